// File: rtl/csr_trap_sequencer_if.sv
// Renamer <-> trap sequencer <-> CSRRF bundle: request handshake, CSR read snapshot,
// CSR write strobes and the front-end redirect.
interface csr_trap_sequencer_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CAUSE_W = 6
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_kind;
    logic [CAUSE_W-1:0] req_cause;
    logic [XLEN-1:0]    req_pc;
    logic [XLEN-1:0]    req_tval;
    logic [1:0]         cur_priv;

    logic [XLEN-1:0]    medeleg_rdata;
    logic [XLEN-1:0]    mideleg_rdata;
    logic [XLEN-1:0]    mstatus_rdata;
    logic [XLEN-1:0]    mtvec_rdata;
    logic [XLEN-1:0]    stvec_rdata;
    logic [XLEN-1:0]    mepc_rdata;
    logic [XLEN-1:0]    sepc_rdata;

    logic               mepc_we;
    logic               mcause_we;
    logic               mtval_we;
    logic               mstatus_we;
    logic               sepc_we;
    logic               scause_we;
    logic               stval_we;
    logic [XLEN-1:0]    mepc_wdata;
    logic [XLEN-1:0]    mcause_wdata;
    logic [XLEN-1:0]    mtval_wdata;
    logic [XLEN-1:0]    mstatus_wdata;
    logic [XLEN-1:0]    sepc_wdata;
    logic [XLEN-1:0]    scause_wdata;
    logic [XLEN-1:0]    stval_wdata;

    logic               redir_valid;
    logic [XLEN-1:0]    redir_pc;
    logic [1:0]         redir_priv;

    modport master (
        output req_valid, req_kind, req_cause, req_pc, req_tval, cur_priv,
        output medeleg_rdata, mideleg_rdata, mstatus_rdata, mtvec_rdata,
        output stvec_rdata, mepc_rdata, sepc_rdata,
        input  req_ready,
        input  mepc_we, mcause_we, mtval_we, mstatus_we, sepc_we, scause_we, stval_we,
        input  mepc_wdata, mcause_wdata, mtval_wdata, mstatus_wdata,
        input  sepc_wdata, scause_wdata, stval_wdata,
        input  redir_valid, redir_pc, redir_priv
    );

    modport slave (
        input  req_valid, req_kind, req_cause, req_pc, req_tval, cur_priv,
        input  medeleg_rdata, mideleg_rdata, mstatus_rdata, mtvec_rdata,
        input  stvec_rdata, mepc_rdata, sepc_rdata,
        output req_ready,
        output mepc_we, mcause_we, mtval_we, mstatus_we, sepc_we, scause_we, stval_we,
        output mepc_wdata, mcause_wdata, mtval_wdata, mstatus_wdata,
        output sepc_wdata, scause_wdata, stval_wdata,
        output redir_valid, redir_pc, redir_priv
    );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Sequences one trap/xRET request at a time into CSR write strobes (WRITE cycle)
// and a front-end redirect pulse (REDIR cycle).
module csr_trap_sequencer #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CAUSE_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_trap_sequencer_if.slave csr_bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECIDE = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_REDIR  = 2'd3;

    localparam logic [1:0] KIND_EXC  = 2'd0;
    localparam logic [1:0] KIND_INT  = 2'd1;
    localparam logic [1:0] KIND_MRET = 2'd2;
    localparam logic [1:0] KIND_SRET = 2'd3;

    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int unsigned NCSR        = 7;
    localparam int unsigned CSR_MEPC    = 0;
    localparam int unsigned CSR_MCAUSE  = 1;
    localparam int unsigned CSR_MTVAL   = 2;
    localparam int unsigned CSR_MSTATUS = 3;
    localparam int unsigned CSR_SEPC    = 4;
    localparam int unsigned CSR_SCAUSE  = 5;
    localparam int unsigned CSR_STVAL   = 6;

    localparam int unsigned MS_SIE  = 1;
    localparam int unsigned MS_MIE  = 3;
    localparam int unsigned MS_SPIE = 5;
    localparam int unsigned MS_MPIE = 7;
    localparam int unsigned MS_SPP  = 8;
    localparam int unsigned MS_MPP  = 11;
    localparam int unsigned MS_MPRV = 17;

    logic [1:0]                 state_q, state_d;
    logic                       ready_q, ready_d;
    logic                       deleg_q, deleg_d;
    logic [NCSR-1:0]            we_q, we_d;
    logic [NCSR-1:0][XLEN-1:0]  wdata_q, wdata_d;
    logic                       redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]            redir_pc_q, redir_pc_d;
    logic [1:0]                 redir_priv_q, redir_priv_d;

    logic [1:0]         kind_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    pc_q, tval_q;
    logic [1:0]         priv_q;
    logic [XLEN-1:0]    medeleg_q, mideleg_q, mstatus_q, mtvec_q, stvec_q, mepc_q, sepc_q;

    logic               accept_c;
    logic               is_int_c;
    logic               deleg_c;
    logic [XLEN-1:0]    epc_c, cause_word_c, tval_c, mstatus_c;
    logic [XLEN-1:0]    tvec_c, base_c, trap_pc_c;

    assign accept_c = (state_q == ST_IDLE) && csr_bus.req_valid;

    // Snapshot of the request and the CSR view it was issued against.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q    <= KIND_EXC;
            cause_q   <= '0;
            pc_q      <= '0;
            tval_q    <= '0;
            priv_q    <= PRIV_M;
            medeleg_q <= '0;
            mideleg_q <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            stvec_q   <= '0;
            mepc_q    <= '0;
            sepc_q    <= '0;
        end else if (accept_c) begin
            kind_q    <= csr_bus.req_kind;
            cause_q   <= csr_bus.req_cause;
            pc_q      <= csr_bus.req_pc;
            tval_q    <= csr_bus.req_tval;
            priv_q    <= csr_bus.cur_priv;
            medeleg_q <= csr_bus.medeleg_rdata;
            mideleg_q <= csr_bus.mideleg_rdata;
            mstatus_q <= csr_bus.mstatus_rdata;
            mtvec_q   <= csr_bus.mtvec_rdata;
            stvec_q   <= csr_bus.stvec_rdata;
            mepc_q    <= csr_bus.mepc_rdata;
            sepc_q    <= csr_bus.sepc_rdata;
        end
    end

    // Trap/return arithmetic on the snapshot.
    always_comb begin
        is_int_c = (kind_q == KIND_INT);
        deleg_c  = (priv_q != PRIV_M) &&
                   (is_int_c ? mideleg_q[cause_q] : medeleg_q[cause_q]);
        epc_c    = pc_q & ~XLEN'(1);
        cause_word_c = XLEN'(cause_q);
        cause_word_c[XLEN-1] = is_int_c;
        tval_c   = (kind_q == KIND_EXC) ? tval_q : '0;

        mstatus_c = mstatus_q;
        case (kind_q)
            KIND_MRET: begin
                mstatus_c[MS_MIE]     = mstatus_q[MS_MPIE];
                mstatus_c[MS_MPIE]    = 1'b1;
                mstatus_c[MS_MPP +: 2] = 2'b00;
                if (mstatus_q[MS_MPP +: 2] != PRIV_M) begin
                    mstatus_c[MS_MPRV] = 1'b0;
                end
            end
            KIND_SRET: begin
                mstatus_c[MS_SIE]  = mstatus_q[MS_SPIE];
                mstatus_c[MS_SPIE] = 1'b1;
                mstatus_c[MS_SPP]  = 1'b0;
                mstatus_c[MS_MPRV] = 1'b0;
            end
            default: begin
                if (deleg_c) begin
                    mstatus_c[MS_SPIE] = mstatus_q[MS_SIE];
                    mstatus_c[MS_SIE]  = 1'b0;
                    mstatus_c[MS_SPP]  = priv_q[0];
                end else begin
                    mstatus_c[MS_MPIE]     = mstatus_q[MS_MIE];
                    mstatus_c[MS_MIE]      = 1'b0;
                    mstatus_c[MS_MPP +: 2] = priv_q;
                end
            end
        endcase

        // tvec modes 2/3 fall back to direct; vector offset wraps at XLEN.
        tvec_c    = deleg_q ? stvec_q : mtvec_q;
        base_c    = tvec_c & ~XLEN'(3);
        trap_pc_c = ((tvec_c[1:0] == 2'b01) && is_int_c) ?
                    base_c + (XLEN'(cause_q) << 2) : base_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            deleg_q       <= 1'b0;
            we_q          <= '0;
            wdata_q       <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_priv_q  <= PRIV_M;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            deleg_q       <= deleg_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            redir_priv_q  <= redir_priv_d;
        end
    end

    // Next state; strobes and redirect are loaded one edge ahead so they are registered.
    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        deleg_d       = deleg_q;
        we_d          = '0;
        wdata_d       = wdata_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        redir_priv_d  = redir_priv_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_DECIDE;
                    ready_d = 1'b0;
                end
            end
            ST_DECIDE: begin
                state_d = ST_WRITE;
                deleg_d = deleg_c;
                we_d[CSR_MSTATUS]    = 1'b1;
                wdata_d[CSR_MSTATUS] = mstatus_c;
                if (!kind_q[1]) begin
                    if (deleg_c) begin
                        we_d[CSR_SEPC]      = 1'b1;
                        we_d[CSR_SCAUSE]    = 1'b1;
                        we_d[CSR_STVAL]     = 1'b1;
                        wdata_d[CSR_SEPC]   = epc_c;
                        wdata_d[CSR_SCAUSE] = cause_word_c;
                        wdata_d[CSR_STVAL]  = tval_c;
                    end else begin
                        we_d[CSR_MEPC]      = 1'b1;
                        we_d[CSR_MCAUSE]    = 1'b1;
                        we_d[CSR_MTVAL]     = 1'b1;
                        wdata_d[CSR_MEPC]   = epc_c;
                        wdata_d[CSR_MCAUSE] = cause_word_c;
                        wdata_d[CSR_MTVAL]  = tval_c;
                    end
                end
            end
            ST_WRITE: begin
                state_d       = ST_REDIR;
                redir_valid_d = 1'b1;
                case (kind_q)
                    KIND_MRET: begin
                        redir_pc_d   = mepc_q & ~XLEN'(1);
                        redir_priv_d = mstatus_q[MS_MPP +: 2];
                    end
                    KIND_SRET: begin
                        redir_pc_d   = sepc_q & ~XLEN'(1);
                        redir_priv_d = {1'b0, mstatus_q[MS_SPP]};
                    end
                    default: begin
                        redir_pc_d   = trap_pc_c;
                        redir_priv_d = deleg_q ? PRIV_S : PRIV_M;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign csr_bus.req_ready     = ready_q;
    assign csr_bus.mepc_we       = we_q[CSR_MEPC];
    assign csr_bus.mcause_we     = we_q[CSR_MCAUSE];
    assign csr_bus.mtval_we      = we_q[CSR_MTVAL];
    assign csr_bus.mstatus_we    = we_q[CSR_MSTATUS];
    assign csr_bus.sepc_we       = we_q[CSR_SEPC];
    assign csr_bus.scause_we     = we_q[CSR_SCAUSE];
    assign csr_bus.stval_we      = we_q[CSR_STVAL];
    assign csr_bus.mepc_wdata    = wdata_q[CSR_MEPC];
    assign csr_bus.mcause_wdata  = wdata_q[CSR_MCAUSE];
    assign csr_bus.mtval_wdata   = wdata_q[CSR_MTVAL];
    assign csr_bus.mstatus_wdata = wdata_q[CSR_MSTATUS];
    assign csr_bus.sepc_wdata    = wdata_q[CSR_SEPC];
    assign csr_bus.scause_wdata  = wdata_q[CSR_SCAUSE];
    assign csr_bus.stval_wdata   = wdata_q[CSR_STVAL];
    assign csr_bus.redir_valid   = redir_valid_q;
    assign csr_bus.redir_pc      = redir_pc_q;
    assign csr_bus.redir_priv    = redir_priv_q;
endmodule
